// File: rtl/ac1_pkg.sv
// Shared types and helpers for the AC1 multi-channel windowed accumulator.
package ac1_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      ACC  = 1'b1
   } state_t;

   // Width of a per-cycle bit count for an M-bit word (0..M inclusive).
   function automatic int cw_of(input int m);
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/ac1_lane.sv
// One accumulator channel: saturating adder, zero/add/seed load mux,
// sticky saturation flag and the held result register.
module ac1_lane #(
   parameter int CW    = 5,
   parameter int ACC_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             zero,
   input  logic             add_en,
   input  logic             seed_en,
   input  logic             load_en,
   input  logic [CW-1:0]    add_val,
   input  logic [CW-1:0]    seed_val,
   output logic [ACC_W-1:0] out_acc,
   output logic             out_sat
);

   logic [ACC_W-1:0] acc;
   logic             sat;
   logic [ACC_W:0]   sum;
   logic [ACC_W-1:0] sum_sat;
   logic             sat_next;

   // One extra bit catches the carry that triggers the clamp.
   assign sum      = {1'b0, acc} + (ACC_W+1)'(add_val);
   assign sum_sat  = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
   assign sat_next = sat | sum[ACC_W];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc     <= '0;
         sat     <= 1'b0;
         out_acc <= '0;
         out_sat <= 1'b0;
      end else begin
         if (zero) begin
            acc <= '0;
            sat <= 1'b0;
         end else if (add_en) begin
            if (seed_en) begin
               acc <= ACC_W'(seed_val);
               sat <= 1'b0;
            end else begin
               acc <= sum_sat;
               sat <= sat_next;
            end
         end
         if (load_en) begin
            out_acc <= sum_sat;
            out_sat <= sat_next;
         end
      end
   end

endmodule

// File: rtl/ac1_multi_acc.sv
// Multi-channel windowed accumulator: FSM, beat counter and result handshake;
// per-channel arithmetic lives in ac1_lane.
module ac1_multi_acc
   import ac1_pkg::*;
#(
   parameter  int M       = 16,
   parameter  int CH      = 4,
   parameter  int ACC_W   = 16,
   parameter  int WIN_MAX = 256,
   localparam int CW      = cw_of(M),
   localparam int LW      = $clog2(WIN_MAX) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [LW-1:0]     win_len,
   input  logic              cont_en,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CH*CW-1:0]  in_add,
   input  logic [CH*CW-1:0]  in_breg,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CH*ACC_W-1:0] out_acc,
   output logic [CH-1:0]     out_sat,
   output logic              busy
);

   state_t        state;
   logic [LW-1:0] cnt;
   logic [LW-1:0] win_q;
   logic          cont_q;
   logic          last;
   logic          beat;
   logic          fire;
   logic          start_ok;
   logic          abort;

   // Valid/ready: a beat transfers on an edge where in_valid && in_ready;
   // a result transfers where out_valid && out_ready. The final beat of a
   // window is held off while an unconsumed result would be overwritten.
   assign last     = (cnt == win_q - LW'(1));
   assign in_ready = (state == ACC) && !(last && out_valid && !out_ready);
   assign beat     = in_valid && in_ready && !clear;
   assign fire     = beat && last;
   assign start_ok = (state == IDLE) && start && (win_len != '0) && !clear;
   assign abort    = (state == ACC) && clear;
   assign busy     = (state == ACC);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         win_q     <= '0;
         cont_q    <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_ok) begin
                  state  <= ACC;
                  cnt    <= '0;
                  win_q  <= win_len;
                  cont_q <= cont_en;
               end
            end
            ACC: begin
               if (clear) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (beat) begin
                  if (last) begin
                     cnt <= '0;
                     if (!cont_q) state <= IDLE;
                  end else begin
                     cnt <= cnt + LW'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase

         if (fire)           out_valid <= 1'b1;
         else if (out_ready) out_valid <= 1'b0;
      end
   end

   for (genvar c = 0; c < CH; c++) begin : g_lane
      ac1_lane #(
         .CW    (CW),
         .ACC_W (ACC_W)
      ) u_lane (
         .clk      (clk),
         .rst_n    (rst_n),
         .zero     (start_ok || abort),
         .add_en   (beat),
         .seed_en  (fire && cont_q),
         .load_en  (fire),
         .add_val  (in_add[c*CW +: CW]),
         .seed_val (in_breg[c*CW +: CW]),
         .out_acc  (out_acc[c*ACC_W +: ACC_W]),
         .out_sat  (out_sat[c])
      );
   end

endmodule

// File: tb/tb_ac1_multi_acc.sv
// Directed bench for ac1_multi_acc with a 6-bit accumulator so saturation is reachable.
module tb_ac1_multi_acc;

   localparam int M       = 16;
   localparam int CH      = 4;
   localparam int ACC_W   = 6;
   localparam int WIN_MAX = 256;
   localparam int CW      = 5;
   localparam int LW      = 9;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 start;
   logic [LW-1:0]        win_len;
   logic                 cont_en;
   logic                 clear;
   logic                 in_valid;
   logic                 in_ready;
   logic [CH*CW-1:0]     in_add;
   logic [CH*CW-1:0]     in_breg;
   logic                 out_valid;
   logic                 out_ready;
   logic [CH*ACC_W-1:0]  out_acc;
   logic [CH-1:0]        out_sat;
   logic                 busy;

   int n_tests = 0;
   int n_fail  = 0;

   ac1_multi_acc #(
      .M       (M),
      .CH      (CH),
      .ACC_W   (ACC_W),
      .WIN_MAX (WIN_MAX)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .win_len   (win_len),
      .cont_en   (cont_en),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_add    (in_add),
      .in_breg   (in_breg),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_acc   (out_acc),
      .out_sat   (out_sat),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [CH*CW-1:0] pa(input int a0, input int a1, input int a2, input int a3);
      return {CW'(a3), CW'(a2), CW'(a1), CW'(a0)};
   endfunction

   function automatic logic [CH*ACC_W-1:0] pr(input int a0, input int a1, input int a2, input int a3);
      return {ACC_W'(a3), ACC_W'(a2), ACC_W'(a1), ACC_W'(a0)};
   endfunction

   task automatic do_start(input int len, input logic c);
      @(negedge clk);
      start = 1'b1; win_len = LW'(len); cont_en = c;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_beat(input logic [CH*CW-1:0] a, input logic [CH*CW-1:0] b);
      int waited = 0;
      in_valid = 1'b1; in_add = a; in_breg = b;
      #1;
      while (!in_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL beat_accept: in_ready=%0b required 1 after %0d cycles", in_ready, waited);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic test_reset;
      n_tests++;
      if (out_valid !== 1'b0 || out_acc !== '0 || out_sat !== '0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: valid=%0b acc=%h sat=%b busy=%0b required all 0",
                  out_valid, out_acc, out_sat, busy);
      end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      n_tests++;
      if (busy !== 1'b0 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: busy=%0b in_ready=%0b required 0 0", busy, in_ready);
      end
   endtask

   task automatic test_reset_mid;
      out_ready = 1'b0;
      do_start(1, 1'b0);
      send_beat(pa(5, 5, 5, 5), '0);
      n_tests++;
      if (out_valid !== 1'b1 || out_acc !== pr(5, 5, 5, 5)) begin
         n_fail++;
         $display("FAIL pre_reset_result: valid=%0b acc=%h required 1 %h", out_valid, out_acc, pr(5, 5, 5, 5));
      end
      do_start(4, 1'b0);
      send_beat(pa(5, 5, 5, 5), '0);
      send_beat(pa(5, 5, 5, 5), '0);
      #2 rst_n = 1'b0;
      #1;
      n_tests++;
      if (out_valid !== 1'b0 || out_acc !== '0 || out_sat !== '0 || busy !== 1'b0 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: valid=%0b acc=%h sat=%b busy=%0b rdy=%0b required all 0",
                  out_valid, out_acc, out_sat, busy, in_ready);
      end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      n_tests++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset_idle: busy=%0b valid=%0b required 0 0", busy, out_valid);
      end
   endtask

   task automatic test_single;
      out_ready = 1'b0;
      do_start(4, 1'b0);
      n_tests++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL single_busy: busy=%0b required 1", busy);
      end
      send_beat(pa(3, 2, 0, 1), '0);
      send_beat(pa(7, 2, 0, 1), '0);
      send_beat(pa(16, 2, 0, 1), '0);
      n_tests++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL single_early: out_valid=%0b required 0 before last beat", out_valid);
      end
      send_beat(pa(1, 2, 0, 1), '0);
      n_tests++;
      if (out_valid !== 1'b1 || out_acc !== pr(27, 8, 0, 4) || out_sat !== 4'b0000 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL single_result: valid=%0b acc=%h sat=%b busy=%0b required 1 %h 0000 0",
                  out_valid, out_acc, out_sat, busy, pr(27, 8, 0, 4));
      end
      out_ready = 1'b1;
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0 || out_acc !== pr(27, 8, 0, 4)) begin
         n_fail++;
         $display("FAIL single_consume: valid=%0b acc=%h required 0 %h", out_valid, out_acc, pr(27, 8, 0, 4));
      end
      out_ready = 1'b0;
   endtask

   task automatic test_continuous;
      out_ready = 1'b1;
      do_start(2, 1'b1);
      send_beat(pa(4, 4, 4, 4), pa(0, 0, 0, 0));
      send_beat(pa(4, 4, 4, 4), pa(9, 2, 0, 30));
      n_tests++;
      if (out_valid !== 1'b1 || out_acc !== pr(8, 8, 8, 8) || busy !== 1'b1 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL cont_first: valid=%0b acc=%h busy=%0b rdy=%0b required 1 %h 1 1",
                  out_valid, out_acc, busy, in_ready, pr(8, 8, 8, 8));
      end
      send_beat(pa(1, 1, 1, 1), '0);
      n_tests++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL cont_consumed: out_valid=%0b required 0", out_valid);
      end
      send_beat(pa(1, 1, 1, 1), '0);
      n_tests++;
      if (out_valid !== 1'b1 || out_acc !== pr(11, 4, 2, 32) || out_sat !== 4'b0000) begin
         n_fail++;
         $display("FAIL cont_seeded: valid=%0b acc=%h sat=%b required 1 %h 0000",
                  out_valid, out_acc, out_sat, pr(11, 4, 2, 32));
      end
      out_ready = 1'b0;
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      n_tests++;
      if (busy !== 1'b0 || out_valid !== 1'b1 || out_acc !== pr(11, 4, 2, 32)) begin
         n_fail++;
         $display("FAIL cont_clear: busy=%0b valid=%0b acc=%h required 0 1 %h",
                  busy, out_valid, out_acc, pr(11, 4, 2, 32));
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_saturation;
      out_ready = 1'b1;
      do_start(8, 1'b0);
      for (int i = 0; i < 8; i++) send_beat(pa(16, 1, 0, 0), '0);
      n_tests++;
      if (out_valid !== 1'b1 || out_acc !== pr(63, 8, 0, 0) || out_sat !== 4'b0001) begin
         n_fail++;
         $display("FAIL sat_clamp: valid=%0b acc=%h sat=%b required 1 %h 0001",
                  out_valid, out_acc, out_sat, pr(63, 8, 0, 0));
      end
      do_start(8, 1'b0);
      for (int i = 0; i < 8; i++) send_beat(pa(1, 0, 0, 0), '0);
      n_tests++;
      if (out_valid !== 1'b1 || out_acc !== pr(8, 0, 0, 0) || out_sat !== 4'b0000) begin
         n_fail++;
         $display("FAIL sat_cleared: valid=%0b acc=%h sat=%b required 1 %h 0000",
                  out_valid, out_acc, out_sat, pr(8, 0, 0, 0));
      end
      out_ready = 1'b0;
      @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_backpressure;
      out_ready = 1'b0;
      do_start(1, 1'b1);
      send_beat(pa(3, 0, 0, 0), '0);
      n_tests++;
      if (out_valid !== 1'b1 || out_acc !== pr(3, 0, 0, 0)) begin
         n_fail++;
         $display("FAIL bp_first: valid=%0b acc=%h required 1 %h", out_valid, out_acc, pr(3, 0, 0, 0));
      end
      in_valid = 1'b1; in_add = pa(6, 0, 0, 0); in_breg = '0;
      repeat (2) @(negedge clk);
      n_tests++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_acc !== pr(3, 0, 0, 0)) begin
         n_fail++;
         $display("FAIL bp_stall: rdy=%0b valid=%0b acc=%h required 0 1 %h",
                  in_ready, out_valid, out_acc, pr(3, 0, 0, 0));
      end
      out_ready = 1'b1;
      #1;
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_release: in_ready=%0b required 1", in_ready);
      end
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b1 || out_acc !== pr(6, 0, 0, 0)) begin
         n_fail++;
         $display("FAIL bp_reload: valid=%0b acc=%h required 1 %h", out_valid, out_acc, pr(6, 0, 0, 0));
      end
      in_valid = 1'b0;
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_drain: out_valid=%0b required 0", out_valid);
      end
      out_ready = 1'b0;
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_exit: busy=%0b required 0", busy);
      end
   endtask

   task automatic test_abort_zero;
      out_ready = 1'b0;
      do_start(1, 1'b0);
      send_beat(pa(5, 5, 5, 5), '0);
      do_start(4, 1'b0);
      send_beat(pa(2, 2, 2, 2), '0);
      in_valid = 1'b1; in_add = pa(9, 9, 9, 9); clear = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; clear = 1'b0;
      n_tests++;
      if (busy !== 1'b0 || out_valid !== 1'b1 || out_acc !== pr(5, 5, 5, 5)) begin
         n_fail++;
         $display("FAIL abort_hold: busy=%0b valid=%0b acc=%h required 0 1 %h",
                  busy, out_valid, out_acc, pr(5, 5, 5, 5));
      end
      do_start(0, 1'b0);
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_len: busy=%0b required 0", busy);
      end
      out_ready = 1'b1;
      do_start(4, 1'b0);
      for (int i = 0; i < 4; i++) send_beat(pa(2, 3, 0, 7), '0);
      n_tests++;
      if (out_valid !== 1'b1 || out_acc !== pr(8, 12, 0, 28) || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_restart: valid=%0b acc=%h busy=%0b required 1 %h 0",
                  out_valid, out_acc, busy, pr(8, 12, 0, 28));
      end
      out_ready = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; win_len = '0; cont_en = 1'b0; clear = 1'b0;
      in_valid = 1'b0; in_add = '0; in_breg = '0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      test_reset;
      test_reset_mid;
      test_single;
      test_continuous;
      test_saturation;
      test_backpressure;
      test_abort_zero;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ac1_multi_acc.md
Name: ac1_multi_acc

Overview:
Multi-channel, windowed successor of the AC1 accumulator stage. Each channel adds a per-cycle bit count from its adder over a programmable window of beats. The final sum goes into an output register with a valid/ready handshake. In continuous mode, the accumulator is reseeded from the Bit_Register value at each window boundary with no idle cycle. The block sits between the AC1 adders/Bit_Register and the downstream result collector.

Parameters:
M, 16, bits per input word; per-channel count width CW = $clog2(M)+1
CH, 4, number of independent channels
ACC_W, 16, accumulator and result width per channel (ACC_W >= CW)
WIN_MAX, 256, maximum window length in beats; window field width LW = $clog2(WIN_MAX)+1

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a window; sampled only in IDLE
win_len  in  LW  window length in beats; latched on an accepted start
cont_en  in  1  continuous mode; latched on an accepted start
clear  in  1  synchronous abort of the running window
in_valid  in  1  in_add/in_breg carry a beat
in_ready  out  1  beat accepted when in_valid && in_ready
in_add  in  CH*CW  per-channel adder count, channel c at [c*CW +: CW]
in_breg  in  CH*CW  per-channel Bit_Register seed value
out_valid  out  1  result register holds an unconsumed window result
out_ready  in  1  downstream consumes the result when out_valid && out_ready
out_acc  out  CH*ACC_W  per-channel window sums
out_sat  out  CH  per-channel saturation flag for the held result
busy  out  1  high when the FSM is not in IDLE

Behaviour:
- Reset (asynchronous, rst_n=0) forces: state IDLE, all accumulators 0, beat counter 0, out_valid=0, out_acc=0, out_sat=0, latched win_len/cont_en=0.
- FSM states: IDLE and ACC.
- IDLE -> ACC on start=1 with win_len!=0. On that edge: accumulators := 0, sticky saturation flags := 0, cnt := 0, win_len/cont_en latched.
- start with win_len=0 is ignored and the FSM stays in IDLE.
- start while in ACC is ignored.
- ACC, accepted beat: acc[c] := min(acc[c] + zext(in_add[c]), 2^ACC_W-1). The sum is computed ACC_W+1 bits wide. If the clamp is hit, the channel's sticky sat flag is set. cnt := cnt+1.
- Last beat (accepted beat with cnt == win_len-1):
  - out_acc[c] := the saturated sum including this beat; out_sat[c] := the sticky flag including this beat; out_valid := 1.
  - cont_en=1: acc[c] := zext(in_breg[c]) (the seed replaces the sum, it is not added); flags := 0; cnt := 0; stay in ACC.
  - cont_en=0: go to IDLE; accumulators hold their values.
- in_ready = (state==ACC) && !(cnt==win_len-1 && out_valid && !out_ready). A result is never overwritten. Non-final beats are always accepted while in ACC.
- Handshake: out_valid falls on an edge with out_ready=1 unless a new result loads on the same edge, in which case it stays 1 with the new data. out_acc and out_sat are stable while out_valid && !out_ready.
- clear=1 in ACC: go to IDLE; accumulators := 0; cnt := 0; any beat that cycle is dropped. out_valid/out_acc are untouched. clear has priority over start. clear in IDLE has no effect.
- Latency: the result is visible on out_acc one cycle after the last beat is accepted.
- win_len=1: every accepted beat completes a window.
- A start issued while a previous result is still pending is allowed. Completion of the new window stalls via in_ready.

Decomposition:
- Package ac1_pkg: state enum (IDLE, ACC); helper function cw_of(M) returning $clog2(M)+1.
- Sub-module ac1_lane: one channel. It holds the saturating adder, the load mux (zero / add / breg seed), the sticky sat flag and the result register. It is instantiated CH times via generate.
- The top level holds the FSM, the beat counter and the handshake logic.

Test Plan:
- Reset mid-window: M=16, CH=4, win_len=4, two beats in_add=5 each, then rst_n low mid-cycle -> all outputs and the accumulator go to 0 immediately (asynchronous); after release busy=0.
- Single window: win_len=4, cont_en=0, channel 0 in_add=3,7,16,1 -> out_acc[0]=27 one cycle after beat 4, out_valid=1, busy=0.
- Continuous seeding: win_len=2, cont_en=1, in_add=4,4 with in_breg=9 on beat 2, then in_add=1,1 -> results 8, then 11; no idle cycle between windows.
- Saturation: ACC_W=6, win_len=8, in_add=16 every beat -> out_acc=63, out_sat=1; the next window with in_add=1 gives out_sat=0.
- Backpressure: win_len=1, cont_en=1, out_ready held 0 -> first result held; in_ready=0 while out_valid=1; raising out_ready accepts the next beat on the same edge and no result is lost.
- Abort and zero length: clear during beat 2 of 4 -> IDLE, out_valid unchanged; start with win_len=0 -> busy stays 0.
